// File: rtl/conv3x3_mac.sv
// conv3x3_mac: streaming 3x3 signed convolution over a padded raster with a 3-stage window/product/sum pipeline.
// Optional feature macro CONV_RELU_EN: clamp negative sums to zero in the summation stage.
module conv3x3_mac #(
  parameter int unsigned DW       = 16,
  parameter int unsigned WW       = 8,
  parameter int unsigned OW       = 32,
  parameter int unsigned LINE_MAX = 1024
) (
  input  logic            p_clk,
  input  logic            rst,
  input  logic [DW-1:0]   i_data,
  input  logic            i_valid,
  input  logic [10:0]     line_size,
  input  logic [9*WW-1:0] i_kernel,
  output logic [OW-1:0]   o_data,
  output logic            o_valid,
  output logic            o_busy
);
  localparam int unsigned CW = 11;
  localparam int unsigned AW = $clog2(LINE_MAX);
  localparam int unsigned PW = DW + WW;
  localparam int unsigned SW = PW + 4;

  typedef enum logic {IDLE, RUN} state_e;

  state_e          state_q, state_d;
  logic            prev_valid_q;
  logic [CW-1:0]   s_q, s_d, col_q, col_d, row_q, row_d;
  logic [9*WW-1:0] kern_q, kern_d;
  logic            beat, win_ok, busy_d;
  logic [CW-1:0]   cur_col, cur_row, cur_s;
  logic [AW-1:0]   lb_addr;

  logic [DW-1:0]        lb0_q [LINE_MAX];
  logic [DW-1:0]        lb1_q [LINE_MAX];
  logic [DW-1:0]        win_q [3][3];
  logic                 v0_q, v1_q;
  logic signed [PW-1:0] prod_d [3][3];
  logic signed [PW-1:0] prod_q [3][3];
  logic signed [SW-1:0] sum_c;
  logic [OW-1:0]        o_data_d;

  // Frame control: start detection, beat qualification and raster counters
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    kern_d  = kern_q;
    col_d   = col_q;
    row_d   = row_q;
    beat    = 1'b0;
    cur_col = col_q;
    cur_row = row_q;
    cur_s   = s_q;
    case (state_q)
      IDLE: begin
        if (i_valid && !prev_valid_q &&
            line_size >= CW'(3) && line_size <= CW'(LINE_MAX)) begin
          state_d = RUN;
          s_d     = line_size;
          kern_d  = i_kernel;
          beat    = 1'b1;
          cur_col = '0;
          cur_row = '0;
          cur_s   = line_size;
        end
      end
      RUN: begin
        if (i_valid) beat = 1'b1;
        else         state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (beat) begin
      if (cur_col == cur_s - CW'(1)) begin
        col_d = '0;
        row_d = cur_row + CW'(1);
        if (cur_row == cur_s - CW'(1)) state_d = IDLE;
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
    win_ok  = beat && (cur_row >= CW'(2)) && (cur_col >= CW'(2));
    busy_d  = (state_d == RUN) || win_ok || v0_q || v1_q;
    lb_addr = cur_col[AW-1:0];
  end

  // Products and sum of the registered window/products
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        prod_d[i][j] = PW'($signed(win_q[i][j])) * PW'($signed(kern_q[WW*(3*i+j) +: WW]));
        sum_c        = sum_c + SW'(prod_q[i][j]);
      end
    end
`ifdef CONV_RELU_EN
    if (sum_c[SW-1]) sum_c = '0;
`endif
    o_data_d = v1_q ? OW'(sum_c) : '0;
  end

  // Line buffers hold no reset; a new frame rewrites every entry before reading it
  always_ff @(posedge p_clk) begin
    if (beat) begin
      lb1_q[lb_addr] <= lb0_q[lb_addr];
      lb0_q[lb_addr] <= i_data;
    end
  end

  always_ff @(posedge p_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      prev_valid_q <= 1'b0;
      s_q          <= '0;
      kern_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      v0_q         <= 1'b0;
      v1_q         <= 1'b0;
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_busy       <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_q[i][j]  <= '0;
          prod_q[i][j] <= '0;
        end
      end
    end else begin
      state_q      <= state_d;
      prev_valid_q <= i_valid;
      s_q          <= s_d;
      kern_q       <= kern_d;
      col_q        <= col_d;
      row_q        <= row_d;
      v0_q         <= win_ok;
      v1_q         <= v0_q;
      o_valid      <= v1_q;
      o_data       <= o_data_d;
      o_busy       <= busy_d;
      if (beat) begin
        for (int i = 0; i < 3; i++) begin
          win_q[i][0] <= win_q[i][1];
          win_q[i][1] <= win_q[i][2];
        end
        win_q[0][2] <= lb1_q[lb_addr];
        win_q[1][2] <= lb0_q[lb_addr];
        win_q[2][2] <= i_data;
      end
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) prod_q[i][j] <= prod_d[i][j];
      end
    end
  end
endmodule

// File: tb/tb_conv3x3_mac.sv
// Scoreboard bench for conv3x3_mac: frames are modelled as 2D pixel arrays and each
// window's expected sum and arrival cycle is queued for an independent output monitor.
`timescale 1ns/1ps
module tb_conv3x3_mac;
  localparam int DW = 16;
  localparam int WW = 8;
  localparam int OW = 32;

  logic            p_clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   i_data;
  logic            i_valid;
  logic [10:0]     line_size;
  logic [9*WW-1:0] i_kernel;
  logic [OW-1:0]   o_data;
  logic            o_valid;
  logic            o_busy;

  conv3x3_mac #(.DW(DW), .WW(WW), .OW(OW), .LINE_MAX(1024)) dut (
    .p_clk(p_clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
    .line_size(line_size), .i_kernel(i_kernel),
    .o_data(o_data), .o_valid(o_valid), .o_busy(o_busy)
  );

  always #5 p_clk = ~p_clk;

  typedef struct { int data; int cyc; } exp_t;
  exp_t  exp_q[$];
  exp_t  mon_e;
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  string tname = "init";

  always @(posedge p_clk) cyc <= cyc + 1;

  task automatic chk(input string what, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s/%s: got %0d expected %0d (cycle %0d)", tname, what, got, want, cyc);
    end
  endtask

  // Output monitor: pops one expectation per valid result, checks value and arrival cycle
  always begin
    @(posedge p_clk);
    #1;
    if (o_valid) begin
      if (exp_q.size() == 0) chk("unexpected_result", int'(o_valid), 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("data", $signed(o_data), mon_e.data);
        chk("arrival_cycle", cyc, mon_e.cyc);
      end
    end else begin
      chk("idle_data_zero", $signed(o_data), 0);
    end
  end

  // Drive one frame; nbeats < s*s aborts, rst_at >= 0 pulses reset at that beat
  task automatic run_frame(input string name, input int s, input logic [9*WW-1:0] kern,
                           input int mode, input int cval, input int nbeats, input int rst_at);
    int  pix [32][32];
    int  kc [9];
    bit  legal, last_win, did_rst;
    int  last_c;
    tname    = name;
    legal    = (s >= 3) && (s <= 1024);
    last_win = 1'b0;
    did_rst  = 1'b0;
    last_c   = 0;
    for (int k = 0; k < 9; k++) kc[k] = int'($signed(kern[WW*k +: WW]));
    @(negedge p_clk);
    line_size = 11'(s);
    i_kernel  = kern;
    for (int b = 0; b < nbeats; b++) begin
      int r, c, sum;
      logic signed [DW-1:0] px;
      r = b / s;
      c = b % s;
      if (b == rst_at) begin
        rst = 1'b1;
        i_valid = 1'b0;
        exp_q.delete();
        @(negedge p_clk);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_data", $signed(o_data), 0);
        rst = 1'b0;
        did_rst = 1'b1;
        break;
      end
      case (mode)
        0:       px = DW'(cval);
        1:       px = DW'(s * r + c);
        default: px = DW'($urandom);
      endcase
      if (r < 32 && c < 32) pix[r][c] = int'(px);
      i_data  = px;
      i_valid = 1'b1;
      last_win = legal && r >= 2 && c >= 2;
      if (last_win) begin
        sum = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            sum += pix[r-2+i][c-2+j] * kc[3*i+j];
`ifdef CONV_RELU_EN
        if (sum < 0) sum = 0;
`endif
        exp_q.push_back('{sum, cyc + 3});
      end
      last_c = cyc;
      if (b == 1) chk("busy_in_frame", int'(o_busy), int'(legal));
      @(negedge p_clk);
    end
    i_valid = 1'b0;
    if (last_win && !did_rst) begin
      while (cyc < last_c + 3) @(negedge p_clk);
      chk("busy_last_result", int'(o_busy), 1);
      @(negedge p_clk);
      chk("busy_fall", int'(o_busy), 0);
    end
    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge p_clk);
    repeat (3) @(negedge p_clk);
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("busy_after_drain", int'(o_busy), 0);
    exp_q.delete();
  endtask

  initial begin
    rst       = 1'b1;
    i_valid   = 1'b0;
    i_data    = '0;
    line_size = 11'd5;
    i_kernel  = '0;
    repeat (3) @(negedge p_clk);
    chk("reset_valid", int'(o_valid), 0);
    chk("reset_busy", int'(o_busy), 0);
    chk("reset_data", $signed(o_data), 0);
    rst = 1'b0;
    repeat (2) @(negedge p_clk);

    run_frame("const2_ones",    5, {9{8'h01}}, 0, 2, 25, -1);
    run_frame("ramp_center",    5, 72'h1 << 32, 1, 0, 25, -1);
    run_frame("const100_neg1",  5, {9{8'hFF}}, 0, 100, 25, -1);
    run_frame("maxneg_maxneg",  5, {9{8'h80}}, 0, -32768, 25, -1);
    run_frame("abort_row2",     5, 72'h1 << 32, 1, 0, 15, -1);
    run_frame("after_abort",    5, 72'h1 << 32, 1, 0, 25, -1);
    run_frame("abort_early",    6, {9{8'h03}}, 2, 0, 13, -1);
    run_frame("rst_midframe",   5, {9{8'h01}}, 2, 0, 25, 14);
    run_frame("after_rst",      5, {9{8'h02}}, 2, 0, 25, -1);
    run_frame("illegal_s2",     2, {9{8'h01}}, 0, 7, 4, -1);
    run_frame("illegal_s1025",  1025, {9{8'h01}}, 0, 7, 30, -1);
    run_frame("legal_s3",       3, {9{8'h01}}, 2, 0, 9, -1);
    for (int n = 0; n < 8; n++) begin
      logic [9*WW-1:0] kr;
      int sr;
      for (int k = 0; k < 9; k++) kr[WW*k +: WW] = WW'($urandom);
      sr = int'($urandom_range(12, 3));
      run_frame($sformatf("random%0d", n), sr, kr, 2, 0, sr * sr, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end
endmodule
